// File: rtl/nibble_serial_adder.sv
// 16-bit adder that reuses one 4-bit carry-lookahead stage over four cycles,
// LSB nibble first, with a valid/ready handshake on both sides.
module nibble_cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [3:0] g, p;
  logic [3:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Carries are flattened generate/propagate terms rather than a ripple chain.
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);
  assign s    = p ^ c;
endmodule

module nibble_serial_adder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] Sum,
  output logic        Cout,
  output logic        Ovf,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic        carry_q, carry_d;
  logic [15:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [15:0] sum_q, sum_d;
  logic        cout_q, cout_d, ovf_q, ovf_d;

  logic [3:0]  st_a, st_b, st_sum;
  logic        st_co;

  assign st_a = a_q[{idx_q, 2'b00} +: 4];
  assign st_b = b_q[{idx_q, 2'b00} +: 4];

  nibble_cla4 u_cla (
    .a  (st_a),
    .b  (st_b),
    .ci (carry_q),
    .s  (st_sum),
    .co (st_co)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = CALC;
          a_d     = A;
          b_d     = B;
          idx_d   = 2'd0;
          carry_d = Cin;
          res_d   = 16'h0000;
        end
      end
      CALC: begin
        res_d[{idx_q, 2'b00} +: 4] = st_sum;
        carry_d = st_co;
        idx_d   = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = DONE;
          sum_d   = {st_sum, res_q[11:0]};
          cout_d  = st_co;
          // Carry into bit 15 is recovered from the latched operand MSBs and sum MSB.
          ovf_d   = a_q[15] ^ b_q[15] ^ st_sum[3] ^ st_co;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      carry_q <= 1'b0;
      a_q     <= 16'h0000;
      b_q     <= 16'h0000;
      res_q   <= 16'h0000;
      sum_q   <= 16'h0000;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign Sum       = sum_q;
  assign Cout      = cout_q;
  assign Ovf       = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: directed vectors, backpressure,
// asynchronous reset mid-operation and a randomized back-to-back stream.
module tb_nibble_serial_adder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        Cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] Sum;
  logic        Cout;
  logic        Ovf;
  logic        busy;

  int checks = 0;
  int failures = 0;

  nibble_serial_adder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin), .out_valid(out_valid), .out_ready(out_ready),
    .Sum(Sum), .Cout(Cout), .Ovf(Ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain 17-bit arithmetic; signed overflow when like-signed operands give an opposite-signed sum.
  function automatic logic [17:0] ref_add(input logic [15:0] a, input logic [15:0] b, input logic c);
    logic [16:0] t;
    logic        o;
    t = {1'b0, a} + {1'b0, b} + {16'b0, c};
    o = (a[15] == b[15]) && (t[15] != a[15]);
    return {o, t};
  endfunction

  task automatic test_reset();
    checks++;
    if ({out_valid, busy, in_ready, Sum, Cout, Ovf} !== {1'b0, 1'b0, 1'b1, 16'h0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: got ov=%b busy=%b ir=%b sum=%h c=%b o=%b, want 0 0 1 0000 0 0",
               out_valid, busy, in_ready, Sum, Cout, Ovf);
    end
  endtask

  // Runs one operation and leaves the DUT in DONE with out_ready low.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c, input string nm);
    logic [17:0] e;
    int n;
    e = ref_add(a, b, c);
    out_ready = 1'b0;
    in_valid = 1'b1; A = a; B = b; Cin = c;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL %s_in_ready: got %b want 1", nm, in_ready);
    end
    step();
    in_valid = 1'b0; A = 16'($urandom); B = 16'($urandom); Cin = 1'($urandom);
    n = 1;
    while (out_valid !== 1'b1 && n < 12) begin
      checks++;
      if (in_ready !== 1'b0) begin
        failures++; $display("FAIL %s_busy_ready: in_ready=%b want 0", nm, in_ready);
      end
      step(); n++;
    end
    checks++;
    if (n != 5) begin
      failures++; $display("FAIL %s_latency: got %0d edges want 5", nm, n);
    end
    checks++;
    if ({Sum, Cout, Ovf} !== {e[15:0], e[16], e[17]}) begin
      failures++;
      $display("FAIL %s_result: got sum=%h c=%b o=%b want sum=%h c=%b o=%b",
               nm, Sum, Cout, Ovf, e[15:0], e[16], e[17]);
    end
  endtask

  task automatic release_done(input string nm);
    logic [17:0] held;
    held = {Ovf, Cout, Sum};
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      failures++; $display("FAIL %s_release: got ov=%b ir=%b busy=%b want 0 1 0", nm, out_valid, in_ready, busy);
    end
    checks++;
    if ({Ovf, Cout, Sum} !== held) begin
      failures++; $display("FAIL %s_hold_after: got %h want %h", nm, {Ovf, Cout, Sum}, held);
    end
  endtask

  task automatic test_directed();
    run_op(16'hFFFF, 16'h0001, 1'b0, "wrap");     release_done("wrap");
    run_op(16'h7FFF, 16'h0001, 1'b0, "posovf");   release_done("posovf");
    run_op(16'h8000, 16'h8000, 1'b0, "negovf");   release_done("negovf");
    run_op(16'h1234, 16'h4321, 1'b1, "cin");      release_done("cin");
    run_op(16'h0F0F, 16'h00F1, 1'b0, "ripple");   release_done("ripple");
    run_op(16'hFFFF, 16'hFFFF, 1'b1, "allones");  release_done("allones");
  endtask

  task automatic test_backpressure();
    logic [19:0] held;
    run_op(16'hA5A5, 16'h1111, 1'b1, "bp");
    held = {out_valid, in_ready, Ovf, Cout, Sum};
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; A = 16'($urandom); B = 16'($urandom);
      step();
      checks++;
      if ({out_valid, in_ready, Ovf, Cout, Sum} !== held) begin
        failures++;
        $display("FAIL bp_stall%0d: got %h want %h", i, {out_valid, in_ready, Ovf, Cout, Sum}, held);
      end
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready, busy, Sum} !== {3'b010, held[15:0]}) begin
      failures++;
      $display("FAIL bp_exit: got ov=%b ir=%b busy=%b sum=%h want 0 1 0 %h",
               out_valid, in_ready, busy, Sum, held[15:0]);
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL bp_no_accept: busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_mid_op();
    in_valid = 1'b1; A = 16'h00FF; B = 16'h0001; Cin = 1'b0;
    step();
    in_valid = 1'b0;
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, busy, in_ready, Sum, Cout, Ovf} !== {3'b001, 16'h0, 2'b00}) begin
      failures++;
      $display("FAIL rst_async: got ov=%b busy=%b ir=%b sum=%h c=%b o=%b want 0 0 1 0000 0 0",
               out_valid, busy, in_ready, Sum, Cout, Ovf);
    end
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
        failures++; $display("FAIL rst_after%0d: got ov=%b ir=%b want 0 1", i, out_valid, in_ready);
      end
    end
    run_op(16'h00FF, 16'h0001, 1'b0, "postrst");
    release_done("postrst");
  endtask

  task automatic test_back_to_back();
    logic [32:0] q[$];
    logic [32:0] op;
    logic [17:0] e;
    int results = 0;
    int last = -1;
    int cyc = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    A = 16'($urandom); B = 16'($urandom); Cin = 1'($urandom);
    while (results < 1000 && cyc < 8000) begin
      if (in_ready === 1'b1) q.push_back({A, B, Cin});
      step(); cyc++;
      if (out_valid === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          failures++; $display("FAIL b2b_spurious: out_valid with no pending op at cycle %0d", cyc);
        end else begin
          op = q.pop_front();
          e = ref_add(op[32:17], op[16:1], op[0]);
          if ({Sum, Cout, Ovf} !== {e[15:0], e[16], e[17]}) begin
            failures++;
            $display("FAIL b2b_result%0d: A=%h B=%h Cin=%b got sum=%h c=%b o=%b want sum=%h c=%b o=%b",
                     results, op[32:17], op[16:1], op[0], Sum, Cout, Ovf, e[15:0], e[16], e[17]);
          end
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last != 6) begin
            failures++; $display("FAIL b2b_rate%0d: got %0d cycles want 6", results, cyc - last);
          end
        end
        last = cyc;
        results++;
      end
      A = 16'($urandom); B = 16'($urandom); Cin = 1'($urandom);
    end
    checks++;
    if (results != 1000) begin
      failures++; $display("FAIL b2b_count: got %0d results want 1000", results);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    step(); step(); step(); step(); step(); step();
  endtask

  initial begin
    #12;
    test_reset();
    rst_n = 1'b1;
    step();
    test_directed();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
